ecc_encode_arbiter: RTL

// - Shares one registered SECDED Hamming encoder (11 data -> 5 parity bits) among NUM_REQ

---
 rtl/ecc_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/ecc_encode_arbiter.sv | 106 ++++++++++
 3 files changed

// File: rtl/ecc_pkg.sv
// Shared types and widths for the SECDED encoder arbiter.
package ecc_pkg;

    localparam int unsigned DATA_W = 11;
    localparam int unsigned PAR_W  = 5;
    localparam int unsigned CW_W   = 16;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [PAR_W-1:0]  parity;
    } codeword_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter
    import ecc_pkg::*;
#(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int unsigned IW = $clog2(N);

    always_comb begin
        int unsigned j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr) + k) % N;
            if (!any && req[IW'(j)]) begin
                any           = 1'b1;
                idx           = IW'(j);
                grant[IW'(j)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ecc_encode_arbiter.sv
// Shares one registered SECDED encoder among NUM_REQ requesters; holds the winner's
// data for ENC_HOLD edges so the folded overall-parity bit settles before capture.
module ecc_encode_arbiter
    import ecc_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 3,
    parameter int unsigned ENC_HOLD = 2
) (
    input  logic                           clk,
    input  logic                           rstN,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           resp_valid,
    output logic [$clog2(NUM_REQ)-1:0]     resp_id,
    output logic [CW_W-1:0]                resp_codeword,
    input  logic                           resp_ready,
    output logic [DATA_W-1:0]              enc_data_out,
    input  logic [PAR_W-1:0]               enc_parity_in,
    output logic                           busy
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(ENC_HOLD + 1);

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [DATA_W-1:0]  hold_q, hold_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_any;
    codeword_t          cw;

    rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            hold_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            hold_q   <= hold_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        id_d       = id_q;
        hold_d     = hold_q;
        cnt_d      = cnt_q;
        req_ready  = '0;
        resp_valid = 1'b0;
        resp_id    = '0;
        cw         = '0;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    req_ready = grant;
                    hold_d    = req_data[grant_idx];
                    id_d      = grant_idx;
                    cnt_d     = '0;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ENC_HOLD - 1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_id    = id_q;
                cw.data    = hold_q;
                cw.parity  = enc_parity_in;
                if (resp_ready) begin
                    rr_ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign resp_codeword = cw;
    assign enc_data_out  = hold_q;
    assign busy          = (state_q != IDLE);

endmodule
